// File: rtl/bbc_bus_seq_pkg.sv
// Shared definitions for the BBC bus sequencer: state encoding, parameter
// defaults and the layout of the configuration register.
package bbc_bus_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_PH1   = 3'd2,
        ST_PH2   = 3'd3,
        ST_LAST  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int unsigned SYNC_STAGES_DEF = 2;
    localparam int unsigned TIMEOUT_DEF     = 255;

    // Bit 0 is the LSB; reserved bits are stored and read back as written.
    typedef struct packed {
        logic [4:0] rsvd;
        logic       loram_ovl;
        logic       rom_ovl;
        logic       himem_en;
    } cfg_t;

endpackage

// File: rtl/phi0_sync.sv
// Brings the BBC 2MHz phi0 into the ck8 domain and produces single-cycle
// rise/fall pulses from the synchronised level.
module phi0_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic phs_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | SYNC_STAGES'(async_i);
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign phs_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = phs_o & ~prev_q;
    assign fall_o = ~phs_o & prev_q;

endmodule

// File: rtl/bbc_bus_seq.sv
// Sequences one CPU access onto the BBC 2MHz/1MHz bus, aligned to phi0 edges,
// with a per-edge timeout and a small configuration register.
module bbc_bus_seq
    import bbc_bus_seq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic       bbc_ck8,
    input  logic       resetb,
    input  logic       bbc_ck2_phi0,
    input  logic       req,
    input  logic       slow,
    input  logic       rnw,
    input  logic       cfg_we,
    input  logic [7:0] cfg_wdata,
    output logic       rdy_o,
    output logic       bbc_cyc,
    output logic       bbc_wr_en,
    output logic       data_le,
    output logic       ack,
    output logic       err,
    output logic [7:0] cfg_q
);

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_e     state_q, state_d;
    logic       rnw_q, rnw_d;
    logic       slow_q, slow_d;
    logic       phase_q, phase_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    cfg_t       cfg_reg_q, cfg_d;

    logic phs, rise, fall;
    logic waiting, timeout;

    phi0_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (bbc_ck8),
        .rst_ni (resetb),
        .async_i(bbc_ck2_phi0),
        .phs_o  (phs),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign waiting = (state_q == ST_ALIGN) || (state_q == ST_PH1) || (state_q == ST_PH2);
    assign timeout = waiting && (cnt_q == TO_CNT);

    always_comb begin
        state_d = state_q;
        rnw_d   = rnw_q;
        slow_d  = slow_q;
        err_d   = err_q;
        cfg_d   = cfg_reg_q;
        rdy_o   = 1'b0;
        bbc_cyc = 1'b0;
        data_le = 1'b0;
        ack     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                rdy_o = ~req;
                if (req) begin
                    rnw_d   = rnw;
                    slow_d  = slow;
                    state_d = ST_ALIGN;
                end else if (cfg_we) begin
                    cfg_d = cfg_t'(cfg_wdata);
                    err_d = 1'b0;
                end
            end
            ST_ALIGN: begin
                if (fall) state_d = ST_PH1;
            end
            ST_PH1: begin
                bbc_cyc = 1'b1;
                if (rise) state_d = ST_PH2;
            end
            ST_PH2: begin
                bbc_cyc = 1'b1;
                // A 1MHz access needs phi0 phase bit 1 at its final fall.
                if (fall) state_d = (slow_q && !phase_q) ? ST_PH1 : ST_LAST;
            end
            ST_LAST: begin
                bbc_cyc = 1'b1;
                data_le = rnw_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ack     = 1'b1;
                rdy_o   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Lost phi0: release the CPU and the bus, flag the error.
        if (timeout) begin
            state_d = ST_IDLE;
            ack     = 1'b1;
            rdy_o   = 1'b1;
            bbc_cyc = 1'b0;
            data_le = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || rise || fall) begin
            cnt_d = 8'd0;
        end else if (waiting) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    assign phase_d   = phase_q ^ fall;
    assign bbc_wr_en = bbc_cyc && ((state_q == ST_PH2) || (state_q == ST_LAST)) && !rnw_q && phs;
    assign err       = err_q;
    assign cfg_q     = cfg_reg_q;

    always_ff @(posedge bbc_ck8 or negedge resetb) begin
        if (!resetb) begin
            state_q   <= ST_IDLE;
            rnw_q     <= 1'b1;
            slow_q    <= 1'b0;
            phase_q   <= 1'b0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            cfg_reg_q <= '0;
        end else begin
            state_q   <= state_d;
            rnw_q     <= rnw_d;
            slow_q    <= slow_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            cfg_reg_q <= cfg_d;
        end
    end

endmodule

// File: tb/tb_bbc_bus_seq.sv
// Directed bench for bbc_bus_seq: normal/slow reads and writes, timeout,
// config register gating and mid-access reset, checked through a scoreboard.
module tb_bbc_bus_seq;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       phi0 = 1'b0;
    logic       req = 1'b0;
    logic       slow = 1'b0;
    logic       rnw = 1'b1;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_wdata = 8'h00;
    logic       rdy_o, bbc_cyc, bbc_wr_en, data_le, ack, err;
    logic [7:0] cfg_q;

    int  checks = 0;
    int  errors = 0;
    bit  phi_run = 1'b1;

    typedef struct {
        int lat;     // req cycle to ack cycle; -1 = checked by the caller
        int le;      // number of data_le pulses
        int wr_c;    // cycles with bbc_wr_en high; -1 = checked by the caller
        int wr_win;  // separate bbc_wr_en windows; -1 = checked by the caller
    } exp_t;

    exp_t sb[$];

    bbc_bus_seq dut (
        .bbc_ck8     (clk),
        .resetb      (resetb),
        .bbc_ck2_phi0(phi0),
        .req         (req),
        .slow        (slow),
        .rnw         (rnw),
        .cfg_we      (cfg_we),
        .cfg_wdata   (cfg_wdata),
        .rdy_o       (rdy_o),
        .bbc_cyc     (bbc_cyc),
        .bbc_wr_en   (bbc_wr_en),
        .data_le     (data_le),
        .ack         (ack),
        .err         (err),
        .cfg_q       (cfg_q)
    );

    // ck8 period 10; phi0 half period 40 (4 ck8), edges 3 units before a ck8 rise.
    always #5 clk = ~clk;

    initial begin
        #2;
        forever begin
            #40;
            if (phi_run) phi0 = ~phi0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench 1 unit after the ck8 edge that first samples a fresh phi0 fall.
    task automatic align(input int falls);
        repeat (falls) @(negedge phi0);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_rdy"},   rdy_o,     1'b1);
        chk({tag, "_cyc"},   bbc_cyc,   1'b0);
        chk({tag, "_wr"},    bbc_wr_en, 1'b0);
        chk({tag, "_le"},    data_le,   1'b0);
        chk({tag, "_ack"},   ack,       1'b0);
        chk({tag, "_err"},   err,       1'b0);
        chk({tag, "_cfg"},   cfg_q,     8'h00);
    endtask

    task automatic access(input string tag, input bit a_rnw, input bit a_slow, input exp_t e_in,
                          output int lat, output int wr_c, output int wr_win);
        exp_t e;
        int   n, le_n, le_at, stall_bad, wr_bad;
        bit   done, prev_wr;
        sb.push_back(e_in);
        rnw  = a_rnw;
        slow = a_slow;
        req  = 1'b1;
        n = 0; le_n = 0; le_at = -1; stall_bad = 0; wr_bad = 0;
        wr_c = 0; wr_win = 0; prev_wr = 1'b0; done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (data_le) begin le_n++; le_at = n; end
            if (bbc_wr_en) wr_c++;
            if (bbc_wr_en && !prev_wr) wr_win++;
            if (bbc_wr_en && !bbc_cyc) wr_bad++;
            prev_wr = bbc_wr_en;
            if (ack) begin
                done = 1'b1;
            end else begin
                if (rdy_o) stall_bad++;
                n++;
                if (n == 1) cfg_we = 1'b0;
                if (n > 400) begin
                    chk({tag, "_ack_bound"}, 0, 1);
                    done = 1'b1;
                end
            end
        end
        lat = n;
        e = sb.pop_front();
        chk({tag, "_rdy_at_ack"}, rdy_o, 1'b1);
        chk({tag, "_stall"}, stall_bad, 0);
        chk({tag, "_wr_outside_cyc"}, wr_bad, 0);
        chk({tag, "_le_count"}, le_n, e.le);
        if (e.le > 0) chk({tag, "_le_pos"}, le_at, lat - 1);
        if (e.lat >= 0) chk({tag, "_latency"}, lat, e.lat);
        if (e.wr_c >= 0) chk({tag, "_wr_cycles"}, wr_c, e.wr_c);
        if (e.wr_win >= 0) chk({tag, "_wr_windows"}, wr_win, e.wr_win);
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack_single"}, ack, 1'b0);
        chk({tag, "_idle_rdy"}, rdy_o, 1'b1);
    endtask

    initial begin
        exp_t e;
        int   lat_a, lat_b, wc_a, wc_b, win_a, win_b, lat, wc, win, ack_seen;

        #3;
        reset_vals("rst");
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        repeat (20) @(posedge clk);

        // Aligned accesses: fall seen the cycle after req, rise 4 later, fall 4 after that.
        align(1);
        e = '{lat: 11, le: 1, wr_c: 0, wr_win: 0};
        access("rd", 1'b1, 1'b0, e, lat, wc, win);

        align(1);
        e = '{lat: 11, le: 0, wr_c: 3, wr_win: 1};
        access("wr", 1'b0, 1'b0, e, lat, wc, win);

        // Two slow writes issued on opposite 1MHz phases.
        align(1);
        e = '{lat: -1, le: 0, wr_c: -1, wr_win: -1};
        access("slowA", 1'b0, 1'b1, e, lat_a, wc_a, win_a);
        align((lat_a == 19) ? 1 : 2);
        access("slowB", 1'b0, 1'b1, e, lat_b, wc_b, win_b);
        chk("slow_lat_A_valid", (lat_a == 11) || (lat_a == 19), 1'b1);
        chk("slow_lat_sum", lat_a + lat_b, 30);
        chk("slow_lat_diff", (lat_a > lat_b) ? lat_a - lat_b : lat_b - lat_a, 8);
        chk("slow_win_A", win_a, (lat_a == 19) ? 2 : 1);
        chk("slow_win_B", win_b, (lat_b == 19) ? 2 : 1);
        chk("slow_wrc_A", wc_a, 3 * win_a);
        chk("slow_wrc_B", wc_b, 3 * win_b);

        // phi0 stops low: one cycle IDLE->ALIGN, then the counter runs 0..255 in ALIGN.
        @(negedge phi0);
        phi_run = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        e = '{lat: 256, le: 0, wr_c: 0, wr_win: 0};
        access("tmo", 1'b1, 1'b0, e, lat, wc, win);
        chk("tmo_err_set", err, 1'b1);
        repeat (5) @(negedge clk);
        chk("tmo_err_sticky", err, 1'b1);
        @(posedge clk);
        #1;
        cfg_wdata = 8'h05;
        cfg_we    = 1'b1;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(negedge clk);
        chk("cfg_load", cfg_q, 8'h05);
        chk("cfg_clr_err", err, 1'b0);
        phi_run = 1'b1;
        repeat (30) @(posedge clk);

        // cfg write coinciding with req is ignored; the access still completes.
        align(1);
        cfg_wdata = 8'hA5;
        cfg_we    = 1'b1;
        e = '{lat: 11, le: 1, wr_c: 0, wr_win: 0};
        access("cfgreq", 1'b1, 1'b0, e, lat, wc, win);
        chk("cfgreq_cfg_kept", cfg_q, 8'h05);
        chk("cfgreq_err", err, 1'b0);

        // Reset during PH2 of a write.
        align(1);
        rnw  = 1'b0;
        slow = 1'b0;
        req  = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("mid_wr_active", bbc_wr_en, 1'b1);
        chk("mid_cyc_active", bbc_cyc, 1'b1);
        resetb = 1'b0;
        req    = 1'b0;
        #1;
        reset_vals("midrst");
        ack_seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) ack_seen++;
        end
        resetb = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (ack) ack_seen++;
        end
        chk("midrst_no_ack", ack_seen, 0);
        chk("midrst_sb_empty", sb.size(), 0);

        align(1);
        e = '{lat: 11, le: 0, wr_c: 3, wr_win: 1};
        access("post_rst", 1'b0, 1'b0, e, lat, wc, win);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
